cache_fill_fsm: RTL

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 83 ++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, reads the 8-word block from RAM and writes it into the data array, then updates the tag.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start the fill at the missing word and wrap.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    output logic        mem_req,
    output logic [15:0] mem_address,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_in,
    output logic        fsm_busy,
    output logic        write_data_array,
    output logic [2:0]  data_word_index,
    output logic [15:0] data_out,
    output logic        write_tag_array,
    output logic [15:0] fill_address
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;
    logic [2:0] offset;
    logic [2:0] count;
    logic [2:0] start_offset;
    logic       in_fill;
    logic       in_done;
    logic       accept;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_offset = miss_address[3:1];
`else
    assign start_offset = 3'd0;
`endif

    // The unused encoding falls into the default arm and behaves as IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            offset       <= 3'd0;
            count        <= 3'd0;
            fill_address <= 16'd0;
        end else begin
            case (state)
                FILL: begin
                    if (mem_data_valid) begin
                        offset <= offset + 3'd1;
                        count  <= count + 3'd1;
                        if (count == 3'd7)
                            state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (miss_detected) begin
                        fill_address <= miss_address;
                        offset       <= start_offset;
                        count        <= 3'd0;
                        state        <= FILL;
                    end
                end
            endcase
        end
    end

    assign in_fill = (state == FILL);
    assign in_done = (state == DONE);
    assign accept  = in_fill & mem_data_valid;

    // The offset field is 3 bits wide, so the word address never carries into the block base.
    assign mem_req          = in_fill;
    assign mem_address      = in_fill ? {fill_address[15:4], offset, 1'b0} : 16'd0;
    assign write_data_array = accept;
    assign data_word_index  = accept ? offset : 3'd0;
    assign data_out         = accept ? mem_data_in : 16'd0;
    assign write_tag_array  = in_done;
    assign fsm_busy         = in_fill | in_done | miss_detected;

endmodule
